ddr_led_status: RTL
===================

# ddr_led_status

Parametrised status-LED driver for the DDR3 test designs; successor to the two-LED calibration/error indicator. It shows DDR3 calibration progress as a slow blink, steady-on for a passing test, and, on a test failure, a latched error code flashed as N fast pulses followed by a gap. Upper LEDs show the latched code bits statically. It sits beside the DDR3 read/write test generator and drives the board LEDs directly.

## Interface
- CLK_FREQ_HZ, 50_000_000 — clk_50m frequency in Hz
- LED_NUM, 2 — number of LEDs; minimum 2
- SLOW_MS, 500 — slow blink half-period in ms (calibration blink)
- FAST_MS, 100 — fast pulse on-time and off-time in ms (error code)
- GAP_FAST, 10 — gap after each code burst, in FAST_MS units
- ERR_CODE_W, 3 — error code width

Ports:
- clk_50m  in  1  system clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- init_calib_complete  in  1  DDR3 calibration done (level)
- error_flag  in  1  test error (level or pulse)
- error_code  in  ERR_CODE_W  error class; sampled only when the error latches
- err_clr  in  1  single-cycle pulse; clears the latched error
- led  out  LED_NUM  LED drive, 1 = on, registered
- err_latched  out  1  error currently latched
- err_code_q  out  ERR_CODE_W  latched code

## Operation
- Prescalers: SLOW_CNT = CLK_FREQ_HZ/1000*SLOW_MS and FAST_CNT = CLK_FREQ_HZ/1000*FAST_MS.
  - Each is a free-running counter 0..CNT-1, sized with $clog2(CNT).
  - slow_tick / fast_tick is a one-cycle pulse when its counter equals CNT-1.
- Calibration phase (init_calib_complete = 0):
  - led[0] toggles on every slow_tick.
  - All other LEDs are 0.
  - The error latch and the code FSM are held cleared.
  - error_flag is ignored.
- Error latch:
  - Sets when init_calib_complete = 1, error_flag = 1 and err_latched = 0.
  - err_code_q captures error_code in the same cycle. A captured code of 0 is stored as 1.
  - Further error_flag activity is ignored until the latch is cleared.
  - err_clr clears the latch and the FSM. err_clr wins over a simultaneous set.
  - If error_flag is still high the next cycle, the latch sets again with a fresh code.
- Calibrated, no error: led[0] = 1, led[1] = 1, led[LED_NUM-1:2] = 0.
- Calibrated, error latched:
  - led[0] = 1.
  - led[1] is driven by the code FSM.
  - led[k] = err_code_q[k-2] for 2 ≤ k < min(LED_NUM, ERR_CODE_W+2); any remaining LEDs are 0.
- Code FSM (pulse counter p is ERR_CODE_W bits; gap counter g is $clog2(GAP_FAST+1) bits; transitions only on fast_tick):
  - IDLE: led[1] = 1. Goes to ON when err_latched is set, with p = err_code_q.
  - ON: led[1] = 1. Goes to OFF; p decrements.
  - OFF: led[1] = 0. Goes to ON if p ≠ 0; otherwise goes to GAP with g = GAP_FAST.
  - GAP: led[1] = 0. g decrements; when g reaches 1, goes to ON with p reloaded from err_code_q.
- Falling init_calib_complete at any time returns the block to the calibration phase on the next cycle.
  - The latch is cleared, the FSM goes to IDLE, and led[0] keeps its current value and resumes toggling.

## Timing
- Reset values:
  - led = 0, err_latched = 0, err_code_q = 0.
  - Both prescalers = 0; FSM = IDLE; p = 0, g = 0.
- All outputs are registered. led reflects an input or state change one cycle after the causing edge.
  - First calibration toggle: led[0] = 1 at cycle SLOW_CNT after reset release.
- err_latched and err_code_q are valid the cycle after error_flag is sampled high.
- Prescalers are never reset by status changes, so the FSM starts on the next fast_tick. Start latency is 1..FAST_CNT cycles.
- One code burst lasts 2·N·FAST_CNT cycles, then the gap lasts GAP_FAST·FAST_CNT cycles, repeating while latched.
- err_clr mid-burst: FSM goes to IDLE and led[1] = 1 the cycle after err_clr.
- Asynchronous reset mid-operation: all state returns to the reset values immediately; no glitch-free requirement on led.

## Test plan
Bench parameters: CLK_FREQ_HZ = 20_000, SLOW_MS = 5 (SLOW_CNT = 100), FAST_MS = 1 (FAST_CNT = 20), GAP_FAST = 3, LED_NUM = 4, ERR_CODE_W = 2.
- Reset, calib = 0 for 450 cycles -> led[0] toggles at cycles 100, 200, 300, 400; led[3:1] = 0 throughout.
- calib rises, no error -> led = 4'b0011 one cycle later, stable; err_latched = 0.
- error_flag pulse with error_code = 3 -> err_latched = 1 and err_code_q = 3 next cycle; led[3:2] = 2'b11; led[1] shows 3 pulses of 20 on / 20 off, then 60 cycles off; the burst repeats identically.
- error_code = 0 latched -> err_code_q = 1; a single pulse per burst; a second error_flag with code 2 during the burst is ignored.
- err_clr in the second ON of a burst -> led[1] = 1 and err_latched = 0 next cycle. err_clr coinciding with a held-high error_flag -> clear on cycle n, relatch on cycle n+1.
- calib falls while latched -> next cycle err_latched = 0, led[3:1] = 0, led[0] resumes toggling on slow_tick. Asserting rst_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr_led_status.sv
// Status-LED driver for the DDR3 test designs: calibration blink, steady pass
// indication, and a latched error code flashed as N fast pulses plus a gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no burst running; led[1] on (pass, or waiting for fast_tick)
// ST_ON    | pulse on-time; pulse counter decrements on leaving
// ST_OFF   | pulse off-time; next pulse if any remain, else gap
// ST_GAP   | inter-burst gap of GAP_FAST fast ticks, then code is reloaded
module ddr_led_status #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int LED_NUM     = 2,
    parameter int SLOW_MS     = 500,
    parameter int FAST_MS     = 100,
    parameter int GAP_FAST    = 10,
    parameter int ERR_CODE_W  = 3
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic                  error_flag,
    input  logic [ERR_CODE_W-1:0] error_code,
    input  logic                  err_clr,
    output logic [LED_NUM-1:0]    led,
    output logic                  err_latched,
    output logic [ERR_CODE_W-1:0] err_code_q
);

    localparam int SLOW_CNT = CLK_FREQ_HZ / 1000 * SLOW_MS;
    localparam int FAST_CNT = CLK_FREQ_HZ / 1000 * FAST_MS;
    localparam int SLOW_W   = (SLOW_CNT > 1) ? $clog2(SLOW_CNT) : 1;
    localparam int FAST_W   = (FAST_CNT > 1) ? $clog2(FAST_CNT) : 1;
    localparam int GAP_W    = (GAP_FAST > 0) ? $clog2(GAP_FAST + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    logic [SLOW_W-1:0]     slow_cnt_q, slow_cnt_d;
    logic [FAST_W-1:0]     fast_cnt_q, fast_cnt_d;
    logic                  slow_tick, fast_tick;
    logic                  err_latched_q, err_latched_d;
    logic [ERR_CODE_W-1:0] code_q, code_d;
    state_t                state_q, state_d;
    logic [ERR_CODE_W-1:0] pulse_q, pulse_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [LED_NUM-1:0]    led_q, led_d;
    logic [LED_NUM-1:0]    code_leds;
    logic                  err_drop, err_set;

    // Free-running prescalers; status changes never restart them.
    assign slow_tick = (slow_cnt_q == SLOW_W'(SLOW_CNT - 1));
    assign fast_tick = (fast_cnt_q == FAST_W'(FAST_CNT - 1));

    always_comb begin
        slow_cnt_d = slow_tick ? '0 : slow_cnt_q + SLOW_W'(1);
        fast_cnt_d = fast_tick ? '0 : fast_cnt_q + FAST_W'(1);
    end

    // Clearing (calibration lost or err_clr) has priority over a new set.
    assign err_drop = !init_calib_complete || err_clr;
    assign err_set  = init_calib_complete && error_flag && !err_latched_q;

    always_comb begin
        err_latched_d = err_latched_q;
        code_d        = code_q;
        if (err_drop) begin
            err_latched_d = 1'b0;
            code_d        = '0;
        end else if (err_set) begin
            err_latched_d = 1'b1;
            code_d        = (error_code == '0) ? ERR_CODE_W'(1) : error_code;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        gap_d   = gap_q;
        if (err_drop) begin
            state_d = ST_IDLE;
            pulse_d = '0;
            gap_d   = '0;
        end else if (fast_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (err_latched_q) begin
                        state_d = ST_ON;
                        pulse_d = code_q;
                    end
                end
                ST_ON: begin
                    state_d = ST_OFF;
                    pulse_d = pulse_q - ERR_CODE_W'(1);
                end
                ST_OFF: begin
                    if (pulse_q != '0) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_FAST);
                    end
                end
                ST_GAP: begin
                    if (gap_q <= GAP_W'(1)) begin
                        state_d = ST_ON;
                        pulse_d = code_q;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Static code bits on led[2..]; LEDs beyond the code width stay dark.
    for (genvar k = 0; k < LED_NUM; k++) begin : g_code_led
        if (k >= 2 && (k - 2) < ERR_CODE_W) begin : g_bit
            assign code_leds[k] = code_d[k-2];
        end else begin : g_zero
            assign code_leds[k] = 1'b0;
        end
    end

    // LEDs decode next-state so they change on the same edge as the cause.
    always_comb begin
        led_d = '0;
        if (init_calib_complete) begin
            if (err_latched_d) begin
                led_d = code_leds;
            end
            led_d[0] = 1'b1;
            led_d[1] = (state_d == ST_IDLE) || (state_d == ST_ON);
        end else begin
            led_d[0] = led_q[0] ^ slow_tick;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            slow_cnt_q    <= '0;
            fast_cnt_q    <= '0;
            err_latched_q <= 1'b0;
            code_q        <= '0;
            state_q       <= ST_IDLE;
            pulse_q       <= '0;
            gap_q         <= '0;
            led_q         <= '0;
        end else begin
            slow_cnt_q    <= slow_cnt_d;
            fast_cnt_q    <= fast_cnt_d;
            err_latched_q <= err_latched_d;
            code_q        <= code_d;
            state_q       <= state_d;
            pulse_q       <= pulse_d;
            gap_q         <= gap_d;
            led_q         <= led_d;
        end
    end

    assign led         = led_q;
    assign err_latched = err_latched_q;
    assign err_code_q  = code_q;

endmodule
